addsub_arbiter: RTL

- Shares one combinational 4-bit adder_subtractor datapath (A, B, M in; Sum, OVF, Cout out) between two independent requesters.
- Round-robin arbitration, per-requester valid/ready request and response handshakes, registered operands and results, and a wrapping completed-operation counter.
- Sits between the two client blocks and the single shared arithmetic unit instance, which lives outside this block at the same hierarchy level.

---
 rtl/addsub_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one external combinational W-bit adder/subtractor
// between two requesters using round-robin arbitration.
//
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   reqN_valid/ready/a/b/m      request handshake and operands (m=1: A-B)
//   rspN_valid/ready/sum/ovf/cout  registered response handshake and result
//   au_a/au_b/au_m              operands to the shared unit (0 unless EXEC)
//   au_sum/au_ovf/au_cout       results from the shared unit
//   busy                        high whenever the FSM is not IDLE
//   op_count                    completed responses, wraps modulo 2^CNT_W
module addsub_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req0_m,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic             req1_m,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [W-1:0]     rsp0_sum,
    output logic             rsp0_ovf,
    output logic             rsp0_cout,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp1_sum,
    output logic             rsp1_ovf,
    output logic             rsp1_cout,
    output logic [W-1:0]     au_a,
    output logic [W-1:0]     au_b,
    output logic             au_m,
    input  logic [W-1:0]     au_sum,
    input  logic             au_ovf,
    input  logic             au_cout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_nxt;
    logic           rr_ptr;     // client that wins when both are valid
    logic           owner;      // client of the in-flight operation
    logic [W-1:0]   op_a, op_b;
    logic           op_m;
    logic           grant0, grant1;
    logic           rsp_done;

    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                // Ready is held low while reset is asserted so the reset
                // cycle never shows a grant.
                if (!rst) begin
                    if (req0_valid && (!req1_valid || !rr_ptr))
                        grant0 = 1'b1;
                    else if (req1_valid)
                        grant1 = 1'b1;
                end
                if (grant0 || grant1)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_done = owner ? (rsp1_valid && rsp1_ready)
                                 : (rsp0_valid && rsp0_ready);
                if (rsp_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);
    assign au_a       = (state == EXEC) ? op_a : '0;
    assign au_b       = (state == EXEC) ? op_b : '0;
    assign au_m       = (state == EXEC) ? op_m : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_m       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_sum   <= '0;
            rsp0_ovf   <= 1'b0;
            rsp0_cout  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_sum   <= '0;
            rsp1_ovf   <= 1'b0;
            rsp1_cout  <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner  <= grant1;
                        rr_ptr <= ~grant1;
                        op_a   <= grant1 ? req1_a : req0_a;
                        op_b   <= grant1 ? req1_b : req0_b;
                        op_m   <= grant1 ? req1_m : req0_m;
                    end
                end
                EXEC: begin
                    if (owner) begin
                        rsp1_sum   <= au_sum;
                        rsp1_ovf   <= au_ovf;
                        rsp1_cout  <= au_cout;
                        rsp1_valid <= 1'b1;
                    end else begin
                        rsp0_sum   <= au_sum;
                        rsp0_ovf   <= au_ovf;
                        rsp0_cout  <= au_cout;
                        rsp0_valid <= 1'b1;
                    end
                end
                RESP: begin
                    // Response data returns to 0 after consumption so an idle
                    // client always sees zeros.
                    if (rsp_done) begin
                        op_count <= op_count + 1'b1;
                        if (owner) begin
                            rsp1_valid <= 1'b0;
                            rsp1_sum   <= '0;
                            rsp1_ovf   <= 1'b0;
                            rsp1_cout  <= 1'b0;
                        end else begin
                            rsp0_valid <= 1'b0;
                            rsp0_sum   <= '0;
                            rsp0_ovf   <= 1'b0;
                            rsp0_cout  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
